// File: rtl/image_sched_pkg.sv
// Shared types and constants for the image job scheduler: FSM states,
// engine command encodings and the packed job word width.
package image_sched_pkg;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_ISSUE,
    ST_RUN,
    ST_COOL
  } sched_state_e;

  localparam logic [1:0] CMD_PASS  = 2'd0;
  localparam logic [1:0] CMD_WHITE = 2'd1;
  localparam logic [1:0] CMD_SHIFT = 2'd2;

  // Job word is {cmd, base, len}
  function automatic int job_width(input int addr_w);
    return 2 + 2 * addr_w;
  endfunction

endpackage

// File: rtl/image_job_fifo.sv
// Synchronous job queue with first-word-fall-through head, flush and an
// occupancy count the scheduler uses to precompute its registered flags.
module job_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 40
) (
  input  logic                       clk_p,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk_p) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Flush wins over a same-cycle push or pop
  always_ff @(posedge clk_p) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/image_job_scheduler.sv
// Queues host frame jobs and launches them one at a time on the image engine,
// with a run watchdog, host abort, completion counting and sticky error flags.
module image_job_scheduler
  import image_sched_pkg::*;
#(
  parameter int ADDR_WIDTH     = 19,
  parameter int FIFO_DEPTH     = 4,
  parameter int READY_DELAY    = 1024,
  parameter int TIMEOUT_CYCLES = 500000
) (
  input  logic                  clk_p,
  input  logic                  rst,
  input  logic                  job_valid,
  output logic                  job_ready,
  input  logic [1:0]            job_cmd,
  input  logic [ADDR_WIDTH-1:0] job_base,
  input  logic [ADDR_WIDTH-1:0] job_len,
  input  logic                  abort,
  output logic                  eng_start,
  output logic [1:0]            eng_cmd,
  output logic [ADDR_WIDTH-1:0] eng_base,
  output logic [ADDR_WIDTH-1:0] eng_len,
  output logic                  eng_abort,
  input  logic                  eng_done,
  output logic                  frame_done,
  output logic [15:0]           jobs_done,
  output logic                  busy,
  output logic                  all_ready,
  output logic                  err_zero_len,
  output logic                  err_timeout
);

  localparam int JW = job_width(ADDR_WIDTH);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int IW = $clog2(READY_DELAY + 1);

  sched_state_e    state;
  logic [TW-1:0]   timer;
  logic [IW-1:0]   init_cnt;
  logic            accept;
  logic            enq;
  logic            pop;
  logic            flush;
  logic            init_done;
  logic [CW-1:0]   fifo_cnt;
  logic [CW-1:0]   cnt_nxt;
  logic            fifo_full;
  logic            fifo_empty;
  logic [JW-1:0]   head;

  assign accept    = job_valid && job_ready;
  assign enq       = accept && !fifo_full && (job_len != '0);
  assign pop       = (state == ST_ISSUE);
  assign flush     = abort && ((state == ST_IDLE) || (state == ST_RUN));
  assign init_done = (state == ST_INIT) && (init_cnt == IW'(READY_DELAY - 1));

  // Queue occupancy after this edge; lets the flags below stay registered
  always_comb begin
    cnt_nxt = fifo_cnt + CW'(enq) - CW'(pop);
    if (flush) cnt_nxt = '0;
  end

  job_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (JW)
  ) u_fifo (
    .clk_p (clk_p),
    .rst   (rst),
    .push  (enq),
    .pop   (pop),
    .flush (flush),
    .din   ({job_cmd, job_base, job_len}),
    .head  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

  always_ff @(posedge clk_p) begin
    if (rst) begin
      state        <= ST_INIT;
      init_cnt     <= '0;
      timer        <= '0;
      job_ready    <= 1'b0;
      eng_start    <= 1'b0;
      eng_cmd      <= CMD_PASS;
      eng_base     <= '0;
      eng_len      <= '0;
      eng_abort    <= 1'b0;
      frame_done   <= 1'b0;
      jobs_done    <= '0;
      busy         <= 1'b0;
      all_ready    <= 1'b0;
      err_zero_len <= 1'b0;
      err_timeout  <= 1'b0;
    end else begin
      eng_start  <= 1'b0;
      eng_abort  <= 1'b0;
      frame_done <= 1'b0;
      job_ready  <= ((state != ST_INIT) || init_done) && (cnt_nxt != CW'(FIFO_DEPTH));
      if (accept && (job_len == '0)) err_zero_len <= 1'b1;

      case (state)
        ST_INIT: begin
          busy      <= 1'b0;
          all_ready <= init_done && (cnt_nxt == '0);
          if (init_done) state <= ST_IDLE;
          else           init_cnt <= init_cnt + 1'b1;
        end

        ST_IDLE: begin
          if (abort) begin
            busy      <= 1'b0;
            all_ready <= 1'b1;
          end else if (!fifo_empty) begin
            state     <= ST_ISSUE;
            busy      <= 1'b1;
            all_ready <= 1'b0;
          end else begin
            busy      <= 1'b0;
            all_ready <= (cnt_nxt == '0);
          end
        end

        ST_ISSUE: begin
          eng_cmd   <= head[JW-1 -: 2];
          eng_base  <= head[2*ADDR_WIDTH-1 -: ADDR_WIDTH];
          eng_len   <= head[ADDR_WIDTH-1:0];
          eng_start <= 1'b1;
          timer     <= '0;
          state     <= ST_RUN;
          busy      <= 1'b1;
          all_ready <= 1'b0;
        end

        // Host abort beats completion, completion beats the watchdog
        ST_RUN: begin
          if (abort) begin
            eng_abort <= 1'b1;
            state     <= ST_IDLE;
            busy      <= 1'b0;
            all_ready <= 1'b1;
          end else if (eng_done) begin
            frame_done <= 1'b1;
            jobs_done  <= jobs_done + 16'd1;
            state      <= ST_COOL;
          end else if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
            eng_abort   <= 1'b1;
            err_timeout <= 1'b1;
            state       <= ST_COOL;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        ST_COOL: begin
          state     <= ST_IDLE;
          busy      <= 1'b0;
          all_ready <= (cnt_nxt == '0);
        end

        default: state <= ST_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_image_job_scheduler.sv
// Scenario bench for image_job_scheduler: launches are checked against a
// queue of expected jobs filled as the host handshakes complete.
module tb_image_job_scheduler;
  import image_sched_pkg::*;

  localparam int AW  = 19;
  localparam int DEP = 4;
  localparam int RD  = 16;
  localparam int TO  = 100;

  logic          clk_p = 1'b0;
  logic          rst = 1'b1;
  logic          job_valid = 1'b0;
  logic          job_ready;
  logic [1:0]    job_cmd = 2'd0;
  logic [AW-1:0] job_base = '0;
  logic [AW-1:0] job_len = '0;
  logic          abort = 1'b0;
  logic          eng_start;
  logic [1:0]    eng_cmd;
  logic [AW-1:0] eng_base;
  logic [AW-1:0] eng_len;
  logic          eng_abort;
  logic          eng_done = 1'b0;
  logic          frame_done;
  logic [15:0]   jobs_done;
  logic          busy;
  logic          all_ready;
  logic          err_zero_len;
  logic          err_timeout;

  always #5 clk_p = ~clk_p;

  image_job_scheduler #(
    .ADDR_WIDTH     (AW),
    .FIFO_DEPTH     (DEP),
    .READY_DELAY    (RD),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk_p        (clk_p),
    .rst          (rst),
    .job_valid    (job_valid),
    .job_ready    (job_ready),
    .job_cmd      (job_cmd),
    .job_base     (job_base),
    .job_len      (job_len),
    .abort        (abort),
    .eng_start    (eng_start),
    .eng_cmd      (eng_cmd),
    .eng_base     (eng_base),
    .eng_len      (eng_len),
    .eng_abort    (eng_abort),
    .eng_done     (eng_done),
    .frame_done   (frame_done),
    .jobs_done    (jobs_done),
    .busy         (busy),
    .all_ready    (all_ready),
    .err_zero_len (err_zero_len),
    .err_timeout  (err_timeout)
  );

  typedef struct {
    logic [1:0]    cmd;
    logic [AW-1:0] base;
    logic [AW-1:0] len;
  } job_t;

  job_t sb[$];
  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int last_done = -100;
  int last_abort = -100;
  int n_start = 0;
  int n_abort = 0;
  int n_frame = 0;
  int exp_jobs = 0;

  // One clock: record handshakes into the scoreboard, check every launch
  task automatic tick();
    logic acc;
    job_t j;
    acc    = job_valid && job_ready && !rst;
    j.cmd  = job_cmd;
    j.base = job_base;
    j.len  = job_len;
    @(posedge clk_p);
    #1;
    cyc++;
    if (acc && j.len != '0) sb.push_back(j);
    if (frame_done) begin n_frame++; last_done = cyc; end
    if (eng_abort) begin n_abort++; last_abort = cyc; end
    if (eng_start) begin
      n_start++;
      n_cmp++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL launch_unexpected: got cmd=%0d base=%0d len=%0d, expected no launch", eng_cmd, eng_base, eng_len);
      end else begin
        j = sb.pop_front();
        if ({eng_cmd, eng_base, eng_len} !== {j.cmd, j.base, j.len}) begin
          n_err++;
          $display("FAIL launch_job: got cmd=%0d base=%0d len=%0d, expected cmd=%0d base=%0d len=%0d",
                   eng_cmd, eng_base, eng_len, j.cmd, j.base, j.len);
        end
      end
      n_cmp++;
      if (cyc < last_done + 3) begin
        n_err++;
        $display("FAIL launch_gap: start at %0d, done at %0d, expected gap >= 3", cyc, last_done);
      end
    end
  endtask

  task automatic push_job(input logic [1:0] c, input logic [AW-1:0] b, input logic [AW-1:0] l,
                          output int acc_cyc);
    logic a;
    acc_cyc   = -1;
    job_valid = 1'b1;
    job_cmd   = c;
    job_base  = b;
    job_len   = l;
    for (int i = 0; i < 200 && acc_cyc < 0; i++) begin
      a = job_ready;
      tick();
      if (a) acc_cyc = cyc;
    end
    job_valid = 1'b0;
    if (acc_cyc < 0) begin
      n_cmp++; n_err++;
      $display("FAIL push_timeout: job len=%0d never accepted, expected acceptance", l);
    end
  endtask

  task automatic wait_start(input int bound, output int sc);
    sc = -1;
    for (int i = 0; i < bound && sc < 0; i++) begin
      tick();
      if (eng_start) sc = cyc;
    end
    if (sc < 0) begin
      n_cmp++; n_err++;
      $display("FAIL start_timeout: no eng_start within %0d cycles, expected one", bound);
    end
  endtask

  task automatic send_done();
    eng_done = 1'b1;
    tick();
    eng_done = 1'b0;
    exp_jobs++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    sb.delete();
    exp_jobs = 0;
    last_done = -100;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({job_ready, eng_start, eng_abort, frame_done, busy, all_ready, err_zero_len, err_timeout} !== 8'd0) begin
      n_err++;
      $display("FAIL reset_flags: got %b, expected 00000000",
               {job_ready, eng_start, eng_abort, frame_done, busy, all_ready, err_zero_len, err_timeout});
    end
    n_cmp++;
    if (jobs_done !== 16'd0) begin
      n_err++; $display("FAIL reset_jobs_done: got %0d, expected 0", jobs_done);
    end
  endtask

  task automatic test_power_up();
    int base_c, acc_c, sc;
    do_reset();
    base_c = cyc;
    for (int i = 0; i < 4; i++) tick();
    push_job(CMD_WHITE, 19'd5, 19'd7, acc_c);
    n_cmp++;
    if (acc_c - base_c != RD + 1) begin
      n_err++; $display("FAIL powerup_accept: accepted at cycle %0d, expected %0d", acc_c - base_c, RD + 1);
    end
    wait_start(20, sc);
    n_cmp++;
    if (sc - base_c < RD + 2 || sc != acc_c + 2) begin
      n_err++; $display("FAIL powerup_start: start at cycle %0d, expected %0d", sc - base_c, acc_c - base_c + 2);
    end
    for (int i = 0; i < 5; i++) tick();
    send_done();
    for (int i = 0; i < 3; i++) tick();
  endtask

  task automatic test_single();
    int acc_c, sc;
    push_job(CMD_SHIFT, 19'd0, 19'd120000, acc_c);
    wait_start(20, sc);
    n_cmp++;
    if (sc != acc_c + 2) begin
      n_err++; $display("FAIL single_latency: start %0d cycles after accept, expected 2", sc - acc_c);
    end
    n_cmp++;
    if (busy !== 1'b1) begin
      n_err++; $display("FAIL single_busy: got %b, expected 1", busy);
    end
    for (int i = 0; i < 60; i++) tick();
    send_done();
    n_cmp++;
    if (frame_done !== 1'b1 || jobs_done !== 16'(exp_jobs)) begin
      n_err++; $display("FAIL single_done: frame_done=%b jobs_done=%0d, expected 1 and %0d", frame_done, jobs_done, exp_jobs);
    end
    n_cmp++;
    if (all_ready !== 1'b0) begin
      n_err++; $display("FAIL single_cool_ready: got %b, expected 0", all_ready);
    end
    tick();
    tick();
    n_cmp++;
    if (all_ready !== 1'b1 || frame_done !== 1'b0) begin
      n_err++; $display("FAIL single_all_ready: all_ready=%b frame_done=%b, expected 1 and 0", all_ready, frame_done);
    end
  endtask

  task automatic test_back_to_back();
    int acc_c, sc, d0;
    d0 = exp_jobs;
    push_job(CMD_PASS, 19'd100, 19'd11, acc_c);
    wait_start(20, sc);
    for (int k = 1; k < 5; k++) push_job(2'(k % 3), 19'(1000 * k), 19'(20 + k), acc_c);
    n_cmp++;
    if (job_ready !== 1'b0) begin
      n_err++; $display("FAIL b2b_full_ready: got %b, expected 0", job_ready);
    end
    send_done();
    tick();
    n_cmp++;
    if (job_ready !== 1'b0) begin
      n_err++; $display("FAIL b2b_ready_before_pop: got %b, expected 0", job_ready);
    end
    for (int k = 1; k < 5; k++) begin
      wait_start(20, sc);
      if (k == 1) begin
        n_cmp++;
        if (job_ready !== 1'b1) begin
          n_err++; $display("FAIL b2b_ready_after_pop: got %b, expected 1", job_ready);
        end
      end
      for (int i = 0; i < 3 + k; i++) tick();
      send_done();
    end
    n_cmp++;
    if (jobs_done !== 16'(exp_jobs) || exp_jobs - d0 != 5) begin
      n_err++; $display("FAIL b2b_jobs_done: got %0d, expected %0d", jobs_done, exp_jobs);
    end
    for (int i = 0; i < 4; i++) tick();
  endtask

  task automatic test_zero_len();
    int acc_c, sc, s0;
    s0 = n_start;
    push_job(CMD_WHITE, 19'd50, 19'd0, acc_c);
    push_job(CMD_WHITE, 19'd60, 19'd10, acc_c);
    wait_start(20, sc);
    for (int i = 0; i < 4; i++) tick();
    send_done();
    for (int i = 0; i < 10; i++) tick();
    n_cmp++;
    if (n_start - s0 != 1) begin
      n_err++; $display("FAIL zero_len_starts: got %0d launches, expected 1", n_start - s0);
    end
    n_cmp++;
    if (err_zero_len !== 1'b1) begin
      n_err++; $display("FAIL zero_len_flag: got %b, expected 1", err_zero_len);
    end
  endtask

  task automatic test_watchdog();
    int acc_c, sc, ac, f0;
    logic [15:0] jd0;
    jd0 = jobs_done;
    f0  = n_frame;
    n_cmp++;
    if (err_timeout !== 1'b0) begin
      n_err++; $display("FAIL wd_flag_before: got %b, expected 0", err_timeout);
    end
    push_job(CMD_SHIFT, 19'd7, 19'd300, acc_c);
    wait_start(20, sc);
    push_job(CMD_PASS, 19'd8, 19'd400, acc_c);
    ac = -1;
    for (int i = 0; i < 150 && ac < 0; i++) begin
      tick();
      if (eng_abort) ac = cyc;
    end
    n_cmp++;
    if (ac - sc != TO) begin
      n_err++; $display("FAIL wd_abort_time: abort %0d cycles into RUN, expected %0d", ac - sc, TO);
    end
    n_cmp++;
    if (err_timeout !== 1'b1 || jobs_done !== jd0 || n_frame != f0) begin
      n_err++; $display("FAIL wd_status: err_timeout=%b jobs_done=%0d frames=%0d, expected 1, %0d, %0d",
                        err_timeout, jobs_done, n_frame - f0, jd0, 0);
    end
    wait_start(20, sc);
    n_cmp++;
    if (sc - ac < 3) begin
      n_err++; $display("FAIL wd_next_launch: launch %0d cycles after abort, expected >= 3", sc - ac);
    end
    for (int i = 0; i < 3; i++) tick();
    send_done();
    for (int i = 0; i < 3; i++) tick();
  endtask

  task automatic test_abort();
    int acc_c, sc, s0, a0;
    push_job(CMD_WHITE, 19'd200, 19'd77, acc_c);
    wait_start(20, sc);
    for (int k = 0; k < 3; k++) push_job(CMD_SHIFT, 19'(300 + k), 19'(30 + k), acc_c);
    s0 = n_start;
    a0 = n_abort;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    sb.delete();
    n_cmp++;
    if (eng_abort !== 1'b1 || all_ready !== 1'b1 || busy !== 1'b0) begin
      n_err++; $display("FAIL abort_run: eng_abort=%b all_ready=%b busy=%b, expected 1 1 0", eng_abort, all_ready, busy);
    end
    for (int i = 0; i < 20; i++) tick();
    n_cmp++;
    if (n_start != s0 || n_abort - a0 != 1 || all_ready !== 1'b1) begin
      n_err++; $display("FAIL abort_quiet: starts=%0d aborts=%0d all_ready=%b, expected 0 1 1", n_start - s0, n_abort - a0, all_ready);
    end
    // Reset while a job is running: every output must clear
    push_job(CMD_SHIFT, 19'd12345, 19'd99, acc_c);
    wait_start(20, sc);
    for (int i = 0; i < 3; i++) tick();
    n_cmp++;
    if (err_zero_len !== 1'b1 || err_timeout !== 1'b1) begin
      n_err++; $display("FAIL sticky_errors: zero_len=%b timeout=%b, expected 1 1", err_zero_len, err_timeout);
    end
    a0 = n_abort;
    rst = 1'b1;
    tick();
    n_cmp++;
    if ({job_ready, eng_start, eng_cmd, eng_base, eng_len, eng_abort, frame_done, jobs_done,
         busy, all_ready, err_zero_len, err_timeout} !== '0) begin
      n_err++; $display("FAIL rst_mid_run: cmd=%0d base=%0d len=%0d jobs=%0d busy=%b ready=%b errs=%b%b, expected all 0",
                        eng_cmd, eng_base, eng_len, jobs_done, busy, job_ready, err_zero_len, err_timeout);
    end
    rst = 1'b0;
    sb.delete();
    for (int i = 0; i < 5; i++) tick();
    n_cmp++;
    if (n_abort != a0 || job_ready !== 1'b0) begin
      n_err++; $display("FAIL rst_quiet: aborts=%0d job_ready=%b, expected 0 and 0", n_abort - a0, job_ready);
    end
  endtask

  initial begin
    test_reset();
    test_power_up();
    test_single();
    test_back_to_back();
    test_zero_len();
    test_watchdog();
    test_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/image_job_scheduler.md
Name: image_job_scheduler

Overview:
Sequences the image processing engine over a queue of frame jobs issued by the SDK-side host logic. Each job carries a command, a BRAM base address and a pixel count. Jobs are buffered in a small FIFO and launched one at a time with a start pulse. The block then waits for the engine's done pulse, or aborts on a watchdog timeout, and reports completion and status back to the host.

Parameters:
ADDR_WIDTH, 19, width of BRAM base address and job length
FIFO_DEPTH, 4, job queue entries (power of two, ≥2)
READY_DELAY, 1024, power-up settle cycles before the first job may issue
TIMEOUT_CYCLES, 500000, maximum RUN cycles before the watchdog fires

Ports:
clk_p  in  1  system clock
rst  in  1  reset, synchronous, active-high
job_valid  in  1  host presents a job
job_ready  out  1  queue can accept (= !full)
job_cmd  in  2  processing command (0 pass, 1 white, 2 shift)
job_base  in  ADDR_WIDTH  first pixel address
job_len  in  ADDR_WIDTH  pixel count
abort  in  1  host abort request (level, sampled per cycle)
eng_start  out  1  one-cycle launch pulse to engine
eng_cmd  out  2  command for launched job, held until next launch
eng_base  out  ADDR_WIDTH  base for launched job, held
eng_len  out  ADDR_WIDTH  length for launched job, held
eng_abort  out  1  one-cycle engine abort pulse
eng_done  in  1  engine completion pulse
frame_done  out  1  one-cycle pulse per job completed normally
jobs_done  out  16  count of normally completed jobs
busy  out  1  high in ISSUE/RUN/COOL
all_ready  out  1  high in IDLE with empty queue
err_zero_len  out  1  sticky: zero-length job was offered
err_timeout  out  1  sticky: watchdog fired

Behaviour:
- All outputs are registered. Reset (sync, rst=1 at an edge) clears the state to INIT, FIFO pointers and count to 0, timers to 0, and every output to 0. job_ready is also 0 while in INIT. Reset mid-job drops the job silently, and no eng_abort is pulsed.
- States:
  - INIT: count to READY_DELAY-1, then go to IDLE.
  - IDLE: if FIFO non-empty, go to ISSUE.
  - ISSUE: lasts one cycle. Pop the head, load eng_cmd/base/len and pulse eng_start in the same cycle, clear the watchdog timer, go to RUN.
  - RUN: see priority rules below.
  - COOL: lasts one cycle. Go to IDLE.
- RUN priority, highest first:
  - abort=1: pulse eng_abort, flush the FIFO, go to IDLE.
  - eng_done=1: pulse frame_done, increment jobs_done (wraps at 2^16), go to COOL.
  - timer = TIMEOUT_CYCLES-1: pulse eng_abort, set err_timeout, go to COOL. jobs_done is not incremented.
  - Otherwise increment the timer.
- abort in IDLE flushes the FIFO with no eng_abort pulse. abort in ISSUE or COOL is ignored. eng_done outside RUN is ignored.
- Push: job_valid && job_ready at an edge.
  - job_len=0: the handshake completes but the job is not enqueued, and err_zero_len is set.
  - A push and a pop in the same cycle keep the count unchanged.
  - When full, job_ready=0 even if a pop occurs that cycle.
- Latency:
  - Job accepted at edge N with IDLE and empty queue: ISSUE, and eng_start=1, follow after edge N+2.
  - eng_done at edge M: frame_done=1 after edge M. The next eng_start is no earlier than after edge M+3.
- Sticky errors clear only on rst.
- all_ready = (state==IDLE) && FIFO empty. busy = state in {ISSUE, RUN, COOL}.

Decomposition:
- Package image_sched_pkg holds the state enum (INIT, IDLE, ISSUE, RUN, COOL), the command encodings (CMD_PASS=0, CMD_WHITE=1, CMD_SHIFT=2), and the job struct width constant (2+2*ADDR_WIDTH).
- One sub-module, job_fifo: synchronous FIFO, FIFO_DEPTH deep, with push, pop, flush, full, empty and first-word-fall-through head.
- The FSM, watchdog and counters live in the top module.

Test Plan:
- Power-up: rst then job_valid at cycle 5 → job_ready=0 until INIT completes. eng_start occurs no earlier than cycle READY_DELAY+2.
- Single job (cmd=2, base=0, len=120000): eng_start pulse 2 edges after accept with eng_len=120000. eng_done after 360000 cycles → frame_done pulse, jobs_done=1, all_ready=1 two cycles later.
- Back-to-back: push 5 jobs while engine busy → 5th sees job_ready=0 until first pop. All launch in order, each eng_start ≥3 cycles after the prior eng_done. jobs_done=5.
- Zero length: push len=0, then len=10 → handshake completes for both, only one eng_start (len=10), err_zero_len=1.
- Watchdog: TIMEOUT_CYCLES=100, withhold eng_done → eng_abort at RUN cycle 100, err_timeout=1, jobs_done unchanged, next queued job launches.
- Abort: 3 queued, abort during RUN → eng_abort pulse, FIFO empty, all_ready=1 next cycle, no further eng_start. Repeat with rst mid-RUN → all outputs 0.
